gb_bus_map: RTL and testbench

//  Registered, banked Game Boy address decoder with CPU/OAM-DMA bus sharing.

---
 rtl/gb_map_pkg.sv | 45 ++++
 rtl/gb_bus_map_if.sv | 45 ++++
 rtl/gb_map_decode.sv | 48 ++++
 rtl/gb_bus_map.sv | 167 ++++++++++++++++
 tb/tb_gb_bus_map.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gb_map_pkg
//  Brief    : Game Boy memory map constants, register addresses and the
//             region enumeration shared by the bus-map decoder slice.
//  Revision : 1.0 - initial release
// ============================================================================
package gb_map_pkg;

  // Region boundaries (inclusive limits)
  localparam logic [15:0] BOOT_LIMIT     = 16'h00FF;
  localparam logic [15:0] CGB_BOOT_BASE  = 16'h0200;
  localparam logic [15:0] CGB_BOOT_LIMIT = 16'h08FF;
  localparam logic [15:0] CROM_LIMIT     = 16'h7FFF;
  localparam logic [15:0] VRAM_LIMIT     = 16'h9FFF;
  localparam logic [15:0] CRAM_LIMIT     = 16'hBFFF;
  localparam logic [15:0] WRAM_LIMIT     = 16'hFDFF;
  localparam logic [15:0] ECHO_BASE      = 16'hE000;
  localparam logic [15:0] OAM_LIMIT      = 16'hFE9F;
  localparam logic [15:0] IO_BASE        = 16'hFF00;
  localparam logic [15:0] IO_LIMIT       = 16'hFF7F;
  localparam logic [15:0] HRAM_LIMIT     = 16'hFFFE;
  localparam logic [15:0] IE_ADDR        = 16'hFFFF;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;

  // Banking / lock registers owned by the bus map
  localparam logic [15:0] REG_VBK  = 16'hFF4F;
  localparam logic [15:0] REG_BOOT = 16'hFF50;
  localparam logic [15:0] REG_SVBK = 16'hFF70;

  typedef enum logic [3:0] {
    RGN_NONE = 4'd0,
    RGN_BOOT = 4'd1,
    RGN_CROM = 4'd2,
    RGN_CRAM = 4'd3,
    RGN_VRAM = 4'd4,
    RGN_WRAM = 4'd5,
    RGN_OAM  = 4'd6,
    RGN_IO   = 4'd7,
    RGN_HRAM = 4'd8,
    RGN_IE   = 4'd9
  } region_e;

endpackage
`default_nettype wire

// File: rtl/gb_bus_map_if.sv
`default_nettype none
// ============================================================================
//  Module   : gb_bus_map_if
//  Brief    : CPU/DMA address-source inputs and slave-select outputs of the
//             bus map. "master" is the CPU/DMA side, "slave" the bus map.
//  Revision : 1.0 - initial release
// ============================================================================
interface gb_bus_map_if;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_din;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        dma_active;
  logic [15:0] dma_adr;
  logic        sel_bootrom;
  logic        sel_cart_rom;
  logic        sel_cart_ram;
  logic        sel_vram;
  logic        sel_wram;
  logic        sel_oam;
  logic        sel_io;
  logic        sel_hram;
  logic        sel_ie;
  logic [2:0]  wram_bank;
  logic        vram_bank;
  logic        bootrom_en;
  logic        cpu_blocked;
  logic [7:0]  reg_dout;
  logic        reg_hit;

  modport master (
    output cpu_adr, cpu_din, cpu_wr, cpu_rd, dma_active, dma_adr,
    input  sel_bootrom, sel_cart_rom, sel_cart_ram, sel_vram, sel_wram, sel_oam,
    input  sel_io, sel_hram, sel_ie, wram_bank, vram_bank, bootrom_en,
    input  cpu_blocked, reg_dout, reg_hit
  );

  modport slave (
    input  cpu_adr, cpu_din, cpu_wr, cpu_rd, dma_active, dma_adr,
    output sel_bootrom, sel_cart_rom, sel_cart_ram, sel_vram, sel_wram, sel_oam,
    output sel_io, sel_hram, sel_ie, wram_bank, vram_bank, bootrom_en,
    output cpu_blocked, reg_dout, reg_hit
  );
endinterface
`default_nettype wire

// File: rtl/gb_map_decode.sv
`default_nettype none
// ============================================================================
//  Module   : gb_map_decode
//  Brief    : Combinational address-to-region decoder. With dma_echo set,
//             everything from E000 up maps to WRAM (OAM DMA source echo).
//  Config   : GB_CGB_BOOTROM_EN adds the 0200-08FF bootrom window.
//  Revision : 1.0 - initial release
// ============================================================================
module gb_map_decode
  import gb_map_pkg::*;
(
  input  wire logic [15:0] adr,
  input  wire logic        bootrom_en,
  input  wire logic        dma_echo,
  output region_e          region
);

  // Priority decode: DMA echo, bootrom overlay, then the linear map
  always_comb begin
    region = RGN_NONE;
    if (dma_echo && adr >= ECHO_BASE)
      region = RGN_WRAM;
    else if (bootrom_en && adr <= BOOT_LIMIT)
      region = RGN_BOOT;
`ifdef GB_CGB_BOOTROM_EN
    else if (bootrom_en && adr >= CGB_BOOT_BASE && adr <= CGB_BOOT_LIMIT)
      region = RGN_BOOT;
`endif
    else if (adr <= CROM_LIMIT)
      region = RGN_CROM;
    else if (adr <= VRAM_LIMIT)
      region = RGN_VRAM;
    else if (adr <= CRAM_LIMIT)
      region = RGN_CRAM;
    else if (adr <= WRAM_LIMIT)
      region = RGN_WRAM;
    else if (adr >= OAM_BASE && adr <= OAM_LIMIT)
      region = RGN_OAM;
    else if (adr >= IO_BASE && adr <= IO_LIMIT)
      region = RGN_IO;
    else if (adr > IO_LIMIT && adr <= HRAM_LIMIT)
      region = RGN_HRAM;
    else if (adr == IE_ADDR)
      region = RGN_IE;
  end

endmodule
`default_nettype wire

// File: rtl/gb_bus_map.sv
`default_nettype none
// ============================================================================
//  Module   : gb_bus_map
//  Brief    : Registered, banked Game Boy address decoder with CPU/OAM-DMA
//             bus sharing. Owns FF50 bootrom lock, FF4F VBK and FF70 SVBK.
//             All outputs are registered (one cycle after the address).
//  Config   : GB_CGB_BOOTROM_EN - CGB bootrom window (0000-00FF, 0200-08FF)
//  Revision : 1.0 - initial release
// ============================================================================
module gb_bus_map
  import gb_map_pkg::*;
#(
  parameter int WRAM_BANKS = 2,
  parameter int VRAM_BANKS = 1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  gb_bus_map_if.slave bus
);

  localparam logic [2:0] C_SVBK_MASK = 3'(WRAM_BANKS - 1);

  logic       r_bootrom_en;
  logic       r_vram_bank;
  logic [2:0] r_svbk;
  logic [8:0] r_sel;
  logic [2:0] r_wram_bank;
  logic       r_cpu_blocked;
  logic [7:0] r_reg_dout;
  logic       r_reg_hit;

  logic        w_cpu_acc;
  logic        w_main_en;
  logic [15:0] w_main_adr;
  region_e     w_main_rgn;
  region_e     w_cpu_rgn;
  logic [2:0]  w_svbk_eff;
  logic [2:0]  w_wram_bank;
  logic [8:0]  w_sel;
  logic        w_vbk_we;
  logic        w_svbk_we;
  logic [7:0]  w_reg_dout;
  logic        w_reg_hit;

  assign w_cpu_acc  = bus.cpu_rd | bus.cpu_wr;
  assign w_main_adr = bus.dma_active ? bus.dma_adr : bus.cpu_adr;
  assign w_main_en  = bus.dma_active | w_cpu_acc;

  gb_map_decode u_main_dec (
    .adr        (w_main_adr),
    .bootrom_en (r_bootrom_en),
    .dma_echo   (bus.dma_active),
    .region     (w_main_rgn)
  );

  gb_map_decode u_cpu_dec (
    .adr        (bus.cpu_adr),
    .bootrom_en (r_bootrom_en),
    .dma_echo   (1'b0),
    .region     (w_cpu_rgn)
  );

  // Bank registers only exist on CGB-sized configurations
  generate
    if (VRAM_BANKS == 2) begin : g_vbk
      assign w_vbk_we = bus.cpu_wr && bus.cpu_adr == REG_VBK;
    end else begin : g_no_vbk
      assign w_vbk_we = 1'b0;
    end
    if (WRAM_BANKS > 2) begin : g_svbk
      assign w_svbk_we = bus.cpu_wr && bus.cpu_adr == REG_SVBK;
    end else begin : g_no_svbk
      assign w_svbk_we = 1'b0;
    end
  endgenerate

  // Effective SVBK: masked to the implemented banks, bank 0 aliases bank 1
  always_comb begin
    w_svbk_eff = r_svbk & C_SVBK_MASK;
    if (w_svbk_eff == 3'd0)
      w_svbk_eff = 3'd1;
  end

  // Select vector {boot,crom,cram,vram,wram,oam,io,hram,ie} and WRAM bank
  always_comb begin
    w_sel       = 9'd0;
    w_wram_bank = 3'd0;
    if (w_main_en) begin
      w_sel[8] = (w_main_rgn == RGN_BOOT);
      w_sel[7] = (w_main_rgn == RGN_CROM);
      w_sel[6] = (w_main_rgn == RGN_CRAM);
      w_sel[5] = (w_main_rgn == RGN_VRAM);
      w_sel[4] = (w_main_rgn == RGN_WRAM);
      w_sel[3] = (w_main_rgn == RGN_OAM);
      // Address bit 12 separates the fixed bank (C/E) from the switched one (D/F)
      if (w_main_rgn == RGN_WRAM && w_main_adr[12])
        w_wram_bank = w_svbk_eff;
    end
    if (w_cpu_acc) begin
      w_sel[2] = (w_cpu_rgn == RGN_IO);
      w_sel[1] = (w_cpu_rgn == RGN_HRAM);
      w_sel[0] = (w_cpu_rgn == RGN_IE);
    end
  end

  // Register readback; a simultaneous write wins and suppresses the read
  always_comb begin
    w_reg_dout = 8'hFF;
    w_reg_hit  = 1'b0;
    if (bus.cpu_rd && !bus.cpu_wr) begin
      if (bus.cpu_adr == REG_VBK) begin
        w_reg_dout = {7'h7F, r_vram_bank};
        w_reg_hit  = 1'b1;
      end else if (bus.cpu_adr == REG_SVBK) begin
        w_reg_dout = {5'h1F, r_svbk};
        w_reg_hit  = 1'b1;
      end else if (bus.cpu_adr == REG_BOOT) begin
        w_reg_dout = {7'h7F, ~r_bootrom_en};
        w_reg_hit  = 1'b1;
      end
    end
  end

  // Output registers and banking state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bootrom_en  <= 1'b1;
      r_vram_bank   <= 1'b0;
      r_svbk        <= 3'd0;
      r_sel         <= 9'd0;
      r_wram_bank   <= 3'd0;
      r_cpu_blocked <= 1'b0;
      r_reg_dout    <= 8'hFF;
      r_reg_hit     <= 1'b0;
    end else begin
      r_sel         <= w_sel;
      r_wram_bank   <= w_wram_bank;
      r_cpu_blocked <= bus.dma_active && w_cpu_acc && bus.cpu_adr < IO_BASE;
      r_reg_dout    <= w_reg_dout;
      r_reg_hit     <= w_reg_hit;
      if (bus.cpu_wr && bus.cpu_adr == REG_BOOT && bus.cpu_din[0])
        r_bootrom_en <= 1'b0;
      if (w_vbk_we)
        r_vram_bank <= bus.cpu_din[0];
      if (w_svbk_we)
        r_svbk <= bus.cpu_din[2:0];
    end
  end

  assign bus.sel_bootrom  = r_sel[8];
  assign bus.sel_cart_rom = r_sel[7];
  assign bus.sel_cart_ram = r_sel[6];
  assign bus.sel_vram     = r_sel[5];
  assign bus.sel_wram     = r_sel[4];
  assign bus.sel_oam      = r_sel[3];
  assign bus.sel_io       = r_sel[2];
  assign bus.sel_hram     = r_sel[1];
  assign bus.sel_ie       = r_sel[0];
  assign bus.wram_bank    = r_wram_bank;
  assign bus.vram_bank    = r_vram_bank;
  assign bus.bootrom_en   = r_bootrom_en;
  assign bus.cpu_blocked  = r_cpu_blocked;
  assign bus.reg_dout     = r_reg_dout;
  assign bus.reg_hit      = r_reg_hit;

endmodule
`default_nettype wire

// File: tb/tb_gb_bus_map.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_bus_map
//  Brief    : Self-checking bench for gb_bus_map (WRAM_BANKS=8, VRAM_BANKS=1)
//             with a memory-map reference model.
//  Config   : GB_CGB_BOOTROM_EN selects the CGB bootrom window expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gb_bus_map;

  localparam int WB = 8;
  localparam int VB = 1;

  // Expected/observed output bundle; sel = {boot,crom,cram,vram,wram,oam,io,hram,ie}
  typedef struct packed {
    logic [8:0] sel;
    logic [2:0] wb;
    logic       vb;
    logic       be;
    logic       blk;
    logic [7:0] dout;
    logic       hit;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Model state
  logic       m_boot;
  logic [2:0] m_svbk;
  logic       m_vb;
  obs_t       e;

  gb_bus_map_if bus ();

  gb_bus_map #(.WRAM_BANKS(WB), .VRAM_BANKS(VB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t get_obs();
    obs_t o;
    o.sel  = {bus.sel_bootrom, bus.sel_cart_rom, bus.sel_cart_ram, bus.sel_vram,
              bus.sel_wram, bus.sel_oam, bus.sel_io, bus.sel_hram, bus.sel_ie};
    o.wb   = bus.wram_bank;
    o.vb   = bus.vram_bank;
    o.be   = bus.bootrom_en;
    o.blk  = bus.cpu_blocked;
    o.dout = bus.reg_dout;
    o.hit  = bus.reg_hit;
    return o;
  endfunction

  function automatic bit in_boot_window(input logic [15:0] a);
`ifdef GB_CGB_BOOTROM_EN
    return (a < 16'h0100) || (a >= 16'h0200 && a < 16'h0900);
`else
    return a < 16'h0100;
`endif
  endfunction

  // Reference model: expected outputs after the next edge, then state update
  task automatic model_step(input logic [15:0] c, input logic [7:0] d,
                            input logic rd, input logic wr,
                            input logic dma, input logic [15:0] da);
    logic        acc;
    logic [15:0] a;
    int          eff;
    acc = rd | wr;
    a   = dma ? da : c;
    e   = '0;
    e.dout = 8'hFF;
    if (dma || acc) begin
      if (dma && a >= 16'hE000)                 e.sel[4] = 1'b1;
      else if (m_boot && in_boot_window(a))     e.sel[8] = 1'b1;
      else if (a < 16'h8000)                    e.sel[7] = 1'b1;
      else if (a < 16'hA000)                    e.sel[5] = 1'b1;
      else if (a < 16'hC000)                    e.sel[6] = 1'b1;
      else if (a < 16'hFE00)                    e.sel[4] = 1'b1;
      else if (a < 16'hFEA0)                    e.sel[3] = 1'b1;
      if (e.sel[4]) begin
        eff = int'(m_svbk) % WB;
        if (eff == 0) eff = 1;
        if ((a >= 16'hD000 && a < 16'hE000) || a >= 16'hF000)
          e.wb = 3'(eff);
      end
    end
    if (acc) begin
      e.sel[2] = (c >= 16'hFF00 && c < 16'hFF80);
      e.sel[1] = (c >= 16'hFF80 && c < 16'hFFFF);
      e.sel[0] = (c == 16'hFFFF);
    end
    e.blk = dma && acc && (c < 16'hFF00);
    if (rd && !wr) begin
      if (c == 16'hFF4F)      begin e.dout = {7'h7F, m_vb};    e.hit = 1'b1; end
      else if (c == 16'hFF70) begin e.dout = {5'h1F, m_svbk};  e.hit = 1'b1; end
      else if (c == 16'hFF50) begin e.dout = {7'h7F, ~m_boot}; e.hit = 1'b1; end
    end
    if (wr) begin
      if (c == 16'hFF50 && d[0])   m_boot = 1'b0;
      if (c == 16'hFF4F && VB == 2) m_vb  = d[0];
      if (c == 16'hFF70 && WB > 2) m_svbk = d[2:0];
    end
    e.be = m_boot;
    e.vb = m_vb;
  endtask

  // One bus cycle: drive at negedge, sample 1 time unit after the posedge
  task automatic step(input logic [15:0] c, input logic [7:0] d, input logic rd,
                      input logic wr, input logic dma, input logic [15:0] da);
    @(negedge clk);
    bus.cpu_adr = c; bus.cpu_din = d; bus.cpu_rd = rd; bus.cpu_wr = wr;
    bus.dma_active = dma; bus.dma_adr = da;
    model_step(c, d, rd, wr, dma, da);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.dma_active = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    m_boot = 1'b1; m_svbk = 3'd0; m_vb = 1'b0;
  endtask

  function automatic logic [15:0] rand_adr();
    case ($urandom_range(0, 6))
      0: return 16'($urandom_range(16'h0000, 16'h00FF));
      1: return 16'($urandom_range(16'h0100, 16'h0AFF));
      2: return 16'($urandom_range(16'hC000, 16'hFFFF));
      3: return 16'($urandom_range(16'hFE00, 16'hFFFF));
      4: begin
        case ($urandom_range(0, 9))
          0: return 16'hFF50;
          1, 2, 3: return 16'hFF70;
          default: return 16'hFF4F;
        endcase
      end
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    obs_t o;
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_adr = 16'h8000; bus.cpu_din = 8'h01; bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0;
    bus.dma_active = 1'b1; bus.dma_adr = 16'hE010;
    repeat (3) @(posedge clk);
    #1;
    o = get_obs();
    total++; if (o.sel !== 9'd0) begin bad++; $display("FAIL reset_sel got=%b want=%b", o.sel, 9'd0); end
    total++; if (o.be !== 1'b1) begin bad++; $display("FAIL reset_boot got=%b want=1", o.be); end
    total++; if (o.dout !== 8'hFF) begin bad++; $display("FAIL reset_dout got=%h want=ff", o.dout); end
    total++; if ({o.wb, o.vb, o.blk, o.hit} !== 6'd0) begin
      bad++; $display("FAIL reset_misc got=%b want=000000", {o.wb, o.vb, o.blk, o.hit});
    end
    @(negedge clk);
    reset = 1'b1;
    m_boot = 1'b1; m_svbk = 3'd0; m_vb = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    step(16'h0050, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.sel_bootrom !== 1'b1 || bus.sel_cart_rom !== 1'b0) begin
      bad++; $display("FAIL lock_boot_sel got=%b%b want=10", bus.sel_bootrom, bus.sel_cart_rom);
    end
    step(16'hFF50, 8'h00, 0, 1, 0, 16'h0);
    total++; if (bus.bootrom_en !== 1'b1) begin bad++; $display("FAIL lock_zero_ignored got=%b want=1", bus.bootrom_en); end
    step(16'hFF50, 8'h01, 0, 1, 0, 16'h0);
    total++; if (bus.bootrom_en !== 1'b0) begin bad++; $display("FAIL lock_clear got=%b want=0", bus.bootrom_en); end
    step(16'h0050, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.sel_bootrom !== 1'b0 || bus.sel_cart_rom !== 1'b1) begin
      bad++; $display("FAIL lock_crom_sel got=%b%b want=01", bus.sel_bootrom, bus.sel_cart_rom);
    end
    step(16'hFF50, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.reg_dout !== 8'hFF || bus.reg_hit !== 1'b1) begin
      bad++; $display("FAIL lock_read got=%h/%b want=ff/1", bus.reg_dout, bus.reg_hit);
    end
  endtask

  task automatic test_banks();
    do_reset();
    step(16'hFF70, 8'h00, 0, 1, 0, 16'h0);
    step(16'hD123, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.wram_bank !== 3'd1 || bus.sel_wram !== 1'b1) begin
      bad++; $display("FAIL bank_zero_alias got=%0d/%b want=1/1", bus.wram_bank, bus.sel_wram);
    end
    step(16'hFF70, 8'h05, 0, 1, 0, 16'h0);
    step(16'hD123, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.wram_bank !== 3'd5) begin bad++; $display("FAIL bank_d got=%0d want=5", bus.wram_bank); end
    step(16'hF123, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.wram_bank !== 3'd5) begin bad++; $display("FAIL bank_echo_f got=%0d want=5", bus.wram_bank); end
    step(16'hC123, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.wram_bank !== 3'd0) begin bad++; $display("FAIL bank_c got=%0d want=0", bus.wram_bank); end
    step(16'hFF70, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.reg_dout !== 8'hFD || bus.reg_hit !== 1'b1) begin
      bad++; $display("FAIL bank_read got=%h/%b want=fd/1", bus.reg_dout, bus.reg_hit);
    end
    step(16'hFF70, 8'h02, 1, 1, 0, 16'h0);
    total++; if (bus.reg_hit !== 1'b0 || bus.reg_dout !== 8'hFF) begin
      bad++; $display("FAIL rdwr_hit got=%h/%b want=ff/0", bus.reg_dout, bus.reg_hit);
    end
  endtask

  task automatic test_dma();
    do_reset();
    step(16'h8000, 8'h00, 1, 0, 1, 16'hE010);
    total++; if ({bus.sel_wram, bus.sel_vram, bus.cpu_blocked} !== 3'b101) begin
      bad++; $display("FAIL dma_block got=%b want=101", {bus.sel_wram, bus.sel_vram, bus.cpu_blocked});
    end
    step(16'hFF85, 8'h00, 1, 0, 1, 16'hE010);
    total++; if ({bus.sel_wram, bus.sel_hram, bus.cpu_blocked} !== 3'b110) begin
      bad++; $display("FAIL dma_hram got=%b want=110", {bus.sel_wram, bus.sel_hram, bus.cpu_blocked});
    end
    step(16'h0000, 8'h00, 0, 0, 1, 16'hFE50);
    total++; if ({bus.sel_wram, bus.sel_oam} !== 2'b10) begin
      bad++; $display("FAIL dma_fe_echo got=%b want=10", {bus.sel_wram, bus.sel_oam});
    end
  endtask

  task automatic test_vram();
    do_reset();
    step(16'hFF4F, 8'h01, 0, 1, 0, 16'h0);
    total++; if (bus.vram_bank !== 1'b0) begin bad++; $display("FAIL vbk_stuck got=%b want=0", bus.vram_bank); end
    step(16'hFF4F, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.reg_dout !== 8'hFE) begin bad++; $display("FAIL vbk_read got=%h want=fe", bus.reg_dout); end
  endtask

  task automatic test_cgb_window();
    do_reset();
    step(16'h0150, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.sel_cart_rom !== 1'b1) begin bad++; $display("FAIL win_0150 got=%b want=1", bus.sel_cart_rom); end
    step(16'h0300, 8'h00, 1, 0, 0, 16'h0);
`ifdef GB_CGB_BOOTROM_EN
    total++; if (bus.sel_bootrom !== 1'b1) begin bad++; $display("FAIL win_0300 got=%b want=1", bus.sel_bootrom); end
`else
    total++; if (bus.sel_cart_rom !== 1'b1) begin bad++; $display("FAIL win_0300 got=%b want=1", bus.sel_cart_rom); end
`endif
    step(16'h0900, 8'h00, 1, 0, 0, 16'h0);
    total++; if (bus.sel_cart_rom !== 1'b1) begin bad++; $display("FAIL win_0900 got=%b want=1", bus.sel_cart_rom); end
  endtask

  // Register write under DMA: same-cycle decode sees old SVBK, next cycle new
  task automatic test_back_to_back();
    do_reset();
    step(16'hFF70, 8'h03, 0, 1, 1, 16'hD000);
    total++; if (bus.wram_bank !== 3'd1) begin bad++; $display("FAIL b2b_old got=%0d want=1", bus.wram_bank); end
    step(16'hFF70, 8'h06, 0, 1, 1, 16'hD000);
    total++; if (bus.wram_bank !== 3'd3) begin bad++; $display("FAIL b2b_new got=%0d want=3", bus.wram_bank); end
    step(16'h0000, 8'h00, 0, 0, 1, 16'hF800);
    total++; if (bus.wram_bank !== 3'd6) begin bad++; $display("FAIL b2b_last got=%0d want=6", bus.wram_bank); end
  endtask

  task automatic test_random();
    obs_t o;
    logic rd, wr, dma;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(0, 2) != 0);
      wr  = ($urandom_range(0, 3) == 0);
      dma = ($urandom_range(0, 3) == 0);
      step(rand_adr(), 8'($urandom), rd, wr, dma, rand_adr());
      o = get_obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", i, o, e);
      end
    end
  endtask

  initial begin
    bus.cpu_adr = 16'h0; bus.cpu_din = 8'h0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.dma_active = 1'b0; bus.dma_adr = 16'h0;
    m_boot = 1'b1; m_svbk = 3'd0; m_vb = 1'b0;
    test_reset();
    test_lock();
    test_banks();
    test_dma();
    test_vram();
    test_cgb_window();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
